// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ID/EX ALU control stage: ALU operation codes,
// main-decoder ALU classes, the M-extension funct7 marker and the mul/div FSM states.
package alu_ctrl_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_REG    = 2'b10;
    localparam logic [1:0] ALUOP_RSVD   = 2'b11;

    localparam logic [6:0] MD_FUNCT7 = 7'b0000001;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU function decode: instruction fields and ALU class to an
// ALU operation code, a mul/div marker and an illegal-function flag.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
#(
    parameter int ENABLE_M = 1
) (
    input  logic       op5,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       funct7_0,
    input  logic [1:0] alu_op,
    output logic [3:0] ctrl,
    output logic       is_md,
    output logic       illegal
);

    always_comb begin
        ctrl    = ALU_ADD;
        is_md   = 1'b0;
        illegal = 1'b0;
        case (alu_op)
            ALUOP_MEM: ctrl = ALU_ADD;
            ALUOP_BRANCH: begin
                case (funct3)
                    3'b000, 3'b001: ctrl = ALU_SUB;
                    3'b100, 3'b101: ctrl = ALU_SLT;
                    3'b110, 3'b111: ctrl = ALU_SLTU;
                    3'b010, 3'b011: begin
                        ctrl    = ALU_ADD;
                        illegal = 1'b1;
                    end
                endcase
            end
            ALUOP_REG: begin
                // Mul/div ops still present ADD so the EX ALU output is benign.
                if (op5 && (funct7_0 == MD_FUNCT7[0])) begin
                    ctrl = ALU_ADD;
                    if (ENABLE_M != 0) begin
                        is_md = 1'b1;
                    end else begin
                        illegal = 1'b1;
                    end
                end else begin
                    case (funct3)
                        3'b000: ctrl = (op5 && funct7_5) ? ALU_SUB : ALU_ADD;
                        3'b001: ctrl = ALU_SLL;
                        3'b010: ctrl = ALU_SLT;
                        3'b011: ctrl = ALU_SLTU;
                        3'b100: ctrl = ALU_XOR;
                        3'b101: ctrl = funct7_5 ? ALU_SRA : ALU_SRL;
                        3'b110: ctrl = ALU_OR;
                        3'b111: ctrl = ALU_AND;
                    endcase
                end
            end
            ALUOP_RSVD: begin
                ctrl    = ALU_ADD;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_ctrl_stage.sv
// ID/EX ALU control register with a start/done handshake to a multi-cycle
// mul/div unit, holding IF/ID via stall_out while that unit is busy.
module alu_ctrl_stage
    import alu_ctrl_pkg::*;
#(
    parameter int CTRL_W   = 4,
    parameter int ENABLE_M = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic              op5,
    input  logic [2:0]        funct3,
    input  logic              funct7_5,
    input  logic              funct7_0,
    input  logic [1:0]        ALUOp,
    input  logic              stall_in,
    input  logic              flush,
    input  logic              md_done,
    output logic [CTRL_W-1:0] ALUControl,
    output logic [2:0]        md_op,
    output logic              md_start,
    output logic              md_abort,
    output logic              ex_valid,
    output logic              illegal_op,
    output logic              stall_out
);

    // ID stage: decode
    logic [3:0] ctrl_p0;
    logic       is_md_p0;
    logic       illegal_p0;

    alu_ctrl_decode #(
        .ENABLE_M (ENABLE_M)
    ) u_decode (
        .op5      (op5),
        .funct3   (funct3),
        .funct7_5 (funct7_5),
        .funct7_0 (funct7_0),
        .alu_op   (ALUOp),
        .ctrl     (ctrl_p0),
        .is_md    (is_md_p0),
        .illegal  (illegal_p0)
    );

    // EX stage: registered control and mul/div FSM
    logic [CTRL_W-1:0] ctrl_p1;
    logic [2:0]        md_op_p1;
    logic              vld_p1;
    logic              illegal_p1;
    logic              md_start_p1;
    md_state_t         state;

    logic md_done_eff;
    logic advance;
    logic accept_md;

    // A done pulse coinciding with our own start pulse cannot belong to this op.
    assign md_done_eff = md_done && !md_start_p1;
    assign stall_out   = (state == BUSY) && !md_done_eff;
    assign md_abort    = (state == BUSY) && flush && !reset;
    assign advance     = !stall_in && !stall_out;
    assign accept_md   = advance && valid_in && is_md_p0 && !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_p1     <= CTRL_W'(ALU_ADD);
            md_op_p1    <= 3'd0;
            vld_p1      <= 1'b0;
            illegal_p1  <= 1'b0;
            md_start_p1 <= 1'b0;
            state       <= IDLE;
        end else if (flush) begin
            ctrl_p1     <= CTRL_W'(ALU_ADD);
            md_op_p1    <= 3'd0;
            vld_p1      <= 1'b0;
            illegal_p1  <= 1'b0;
            md_start_p1 <= 1'b0;
            state       <= IDLE;
        end else begin
            md_start_p1 <= 1'b0;
            if (advance) begin
                ctrl_p1    <= CTRL_W'(ctrl_p0);
                md_op_p1   <= funct3;
                vld_p1     <= valid_in;
                illegal_p1 <= illegal_p0 && valid_in;
            end
            case (state)
                IDLE: begin
                    if (accept_md) begin
                        state       <= BUSY;
                        md_start_p1 <= 1'b1;
                    end
                end
                BUSY: begin
                    if (md_done_eff) begin
                        state       <= accept_md ? BUSY : IDLE;
                        md_start_p1 <= accept_md;
                    end
                end
            endcase
        end
    end

    assign ALUControl = ctrl_p1;
    assign md_op      = md_op_p1;
    assign md_start   = md_start_p1;
    assign ex_valid   = vld_p1;
    assign illegal_op = illegal_p1;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Directed bench for alu_ctrl_stage: one instance with RV32M decode enabled and
// one with it disabled (wider ALUControl), driven from the same ID inputs.
module tb_alu_ctrl_stage;

    logic       clk = 1'b0;
    logic       reset, valid_in, op5, funct7_5, funct7_0, stall_in, flush, md_done;
    logic [2:0] funct3;
    logic [1:0] ALUOp;

    logic [3:0] alu_control;
    logic [2:0] md_op;
    logic       md_start, md_abort, ex_valid, illegal_op, stall_out;

    logic [5:0] nm_alu_control;
    logic [2:0] nm_md_op;
    logic       nm_md_start, nm_md_abort, nm_ex_valid, nm_illegal_op, nm_stall_out;

    int checks = 0;
    int errors = 0;
    logic nm_started = 1'b0;

    always #5 clk = ~clk;

    alu_ctrl_stage #(.CTRL_W(4), .ENABLE_M(1)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .op5(op5), .funct3(funct3),
        .funct7_5(funct7_5), .funct7_0(funct7_0), .ALUOp(ALUOp), .stall_in(stall_in),
        .flush(flush), .md_done(md_done), .ALUControl(alu_control), .md_op(md_op),
        .md_start(md_start), .md_abort(md_abort), .ex_valid(ex_valid),
        .illegal_op(illegal_op), .stall_out(stall_out)
    );

    alu_ctrl_stage #(.CTRL_W(6), .ENABLE_M(0)) dut_nm (
        .clk(clk), .reset(reset), .valid_in(valid_in), .op5(op5), .funct3(funct3),
        .funct7_5(funct7_5), .funct7_0(funct7_0), .ALUOp(ALUOp), .stall_in(stall_in),
        .flush(flush), .md_done(md_done), .ALUControl(nm_alu_control), .md_op(nm_md_op),
        .md_start(nm_md_start), .md_abort(nm_md_abort), .ex_valid(nm_ex_valid),
        .illegal_op(nm_illegal_op), .stall_out(nm_stall_out)
    );

    always @(negedge clk) if (nm_md_start === 1'b1) nm_started = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic p5, input logic [2:0] f3,
                         input logic f75, input logic f70, input logic [1:0] op);
        valid_in = v;
        op5      = p5;
        funct3   = f3;
        funct7_5 = f75;
        funct7_0 = f70;
        ALUOp    = op;
    endtask

    logic [3:0] exp_f0 [8] = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
    logic [3:0] exp_f1 [8] = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd9, 4'd3, 4'd2};

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; stall_in = 1'b0; flush = 1'b0; md_done = 1'b0;
        drive(0, 0, 3'd0, 0, 0, 2'b00);
        repeat (2) tick();
        reset = 1'b0;
        #1;
        chk("rst_ctrl", alu_control, 0);
        chk("rst_md_op", md_op, 0);
        chk("rst_start", md_start, 0);
        chk("rst_valid", ex_valid, 0);
        chk("rst_illegal", illegal_op, 0);
        chk("rst_stall", stall_out, 0);
        chk("rst_abort", md_abort, 0);

        // R-type SUB vs I-type ADD
        drive(1, 1, 3'b000, 1, 0, 2'b10); tick();
        chk("sub_ctrl", alu_control, 1);
        chk("sub_valid", ex_valid, 1);
        chk("sub_illegal", illegal_op, 0);
        drive(1, 0, 3'b000, 1, 0, 2'b10); tick();
        chk("addi_ctrl", alu_control, 0);

        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 3'(i), 0, 0, 2'b10); tick();
            chk("sweep_f0", alu_control, exp_f0[i]);
            chk("sweep_f0_nm", nm_alu_control, {2'b00, exp_f0[i]});
        end
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 3'(i), 1, 0, 2'b10); tick();
            chk("sweep_f1", alu_control, exp_f1[i]);
            chk("sweep_f1_mdop", md_op, i);
        end

        drive(1, 0, 3'b110, 0, 0, 2'b01); tick();
        chk("br_sltu", alu_control, 6);
        drive(1, 0, 3'b010, 0, 0, 2'b01); tick();
        chk("br_bad_ctrl", alu_control, 0);
        chk("br_bad_ill", illegal_op, 1);
        drive(1, 0, 3'b000, 0, 0, 2'b01); tick();
        chk("br_sub", alu_control, 1);
        chk("br_sub_ill", illegal_op, 0);
        drive(1, 0, 3'b000, 0, 0, 2'b11); tick();
        chk("op11_ill", illegal_op, 1);
        drive(0, 0, 3'b000, 0, 0, 2'b11); tick();
        chk("op11_noval_ill", illegal_op, 0);
        chk("op11_noval_vld", ex_valid, 0);

        // downstream stall holds the EX register
        drive(1, 1, 3'b000, 1, 0, 2'b10); stall_in = 1'b1; tick();
        chk("stall_hold_ctrl", alu_control, 0);
        chk("stall_hold_vld", ex_valid, 0);
        stall_in = 1'b0; tick();
        chk("stall_rel_ctrl", alu_control, 1);
        chk("stall_rel_vld", ex_valid, 1);

        // single mul/div op (DIV)
        drive(1, 1, 3'b100, 0, 1, 2'b10); tick();
        chk("md_start", md_start, 1);
        chk("md_op", md_op, 4);
        chk("md_ctrl", alu_control, 0);
        chk("md_vld", ex_valid, 1);
        chk("nm_ctrl", nm_alu_control, 0);
        chk("nm_ill", nm_illegal_op, 1);
        chk("nm_vld", nm_ex_valid, 1);
        chk("nm_stall", nm_stall_out, 0);
        md_done = 1'b1; #1;
        chk("md_done_ignored", stall_out, 1);
        md_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(i[0], 1, 3'b111, 0, 0, 2'b10); tick();
            chk("busy_stall", stall_out, 1);
            chk("busy_start", md_start, 0);
            chk("busy_mdop", md_op, 4);
            chk("busy_ctrl", alu_control, 0);
            chk("busy_vld", ex_valid, 1);
        end
        drive(1, 1, 3'b111, 0, 0, 2'b10); md_done = 1'b1; #1;
        chk("done_stall", stall_out, 0);
        tick(); md_done = 1'b0;
        chk("after_ctrl", alu_control, 2);
        chk("after_mdop", md_op, 7);
        chk("after_start", md_start, 0);
        #1;
        chk("after_stall", stall_out, 0);

        // back-to-back MUL then DIVU
        drive(1, 1, 3'b000, 0, 1, 2'b10); tick();
        chk("b2b_start1", md_start, 1);
        chk("b2b_op1", md_op, 0);
        drive(1, 1, 3'b101, 0, 1, 2'b10); tick();
        chk("b2b_busy_start", md_start, 0);
        chk("b2b_busy_stall", stall_out, 1);
        md_done = 1'b1; #1;
        chk("b2b_done_stall", stall_out, 0);
        tick(); md_done = 1'b0;
        chk("b2b_start2", md_start, 1);
        chk("b2b_op2", md_op, 5);
        chk("b2b_stall2", stall_out, 1);
        tick();
        chk("b2b_start2_once", md_start, 0);
        chk("b2b_still_busy", stall_out, 1);
        valid_in = 1'b0; md_done = 1'b1; tick(); md_done = 1'b0;
        chk("b2b_idle_stall", stall_out, 0);
        chk("b2b_idle_vld", ex_valid, 0);

        // flush on the third BUSY cycle (REM)
        drive(1, 1, 3'b110, 0, 1, 2'b10); tick();
        chk("fl_start", md_start, 1);
        valid_in = 1'b0;
        tick(); tick();
        chk("fl_busy", stall_out, 1);
        flush = 1'b1; #1;
        chk("fl_abort", md_abort, 1);
        tick(); flush = 1'b0;
        chk("fl_vld", ex_valid, 0);
        chk("fl_ctrl", alu_control, 0);
        chk("fl_mdop", md_op, 0);
        chk("fl_start0", md_start, 0);
        #1;
        chk("fl_stall", stall_out, 0);
        chk("fl_abort0", md_abort, 0);
        flush = 1'b1; #1;
        chk("idle_flush_abort", md_abort, 0);
        flush = 1'b0;

        // reset while BUSY (MULHU)
        drive(1, 1, 3'b011, 0, 1, 2'b10); tick();
        chk("rb_busy", stall_out, 1);
        valid_in = 1'b0; reset = 1'b1; #1;
        chk("rb_abort", md_abort, 0);
        tick(); reset = 1'b0;
        chk("rb_ctrl", alu_control, 0);
        chk("rb_mdop", md_op, 0);
        chk("rb_start", md_start, 0);
        chk("rb_vld", ex_valid, 0);
        chk("rb_ill", illegal_op, 0);
        #1;
        chk("rb_stall", stall_out, 0);
        chk("rb_abort0", md_abort, 0);

        // invalid M-op: no start, no illegal
        drive(0, 1, 3'b100, 0, 1, 2'b10); tick();
        chk("inv_md_start", md_start, 0);
        chk("inv_md_stall", stall_out, 0);
        chk("inv_nm_ill", nm_illegal_op, 0);
        tick();
        chk("nm_never_start", nm_started, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
